// File: rtl/cla_pipe_adder_if.sv
// Handshake/data bundle for cla_pipe_adder: upstream operands, downstream result.
interface cla_pipe_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             Sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output in_valid, A, B, Cin, Sub, out_ready,
    input  in_ready, out_valid, S, Cout, V
  );

  modport slave (
    input  in_valid, A, B, Cin, Sub, out_ready,
    output in_ready, out_valid, S, Cout, V
  );
endinterface

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one 4-bit lookahead group per stage.
// Define CLA_OVF_EN to build the registered signed-overflow output V (else V=0).
module cla_pipe_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cla_pipe_adder_if.slave bus
);
  localparam int unsigned NG = WIDTH / 4;

  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("cla_pipe_adder: WIDTH must be a multiple of 4 and at least 4");
  end

  // {carry_out, sum[3:0]} of one 4-bit lookahead group
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4], p ^ c[3:0]};
  endfunction

  logic             valid_q [NG];
  logic             valid_d [NG];
  logic [WIDTH-1:0] a_q     [NG];
  logic [WIDTH-1:0] a_d     [NG];
  logic [WIDTH-1:0] bx_q    [NG];
  logic [WIDTH-1:0] bx_d    [NG];
  logic [WIDTH-1:0] s_q     [NG];
  logic [WIDTH-1:0] s_d     [NG];
  logic             c_q     [NG];
  logic             c_d     [NG];
  logic             advance;
  logic [WIDTH-1:0] bx_in;
  logic [4:0]       grp;

  // Stage k resolves bit group k from the carry registered by stage k-1;
  // operands travel with the partial sum so upper groups stay aligned.
  always_comb begin
    advance = !valid_q[NG-1] || bus.out_ready;
    bx_in   = bus.Sub ? ~bus.B : bus.B;
    grp     = '0;
    for (int unsigned k = 0; k < NG; k++) begin
      valid_d[k] = valid_q[k];
      a_d[k]     = a_q[k];
      bx_d[k]    = bx_q[k];
      s_d[k]     = s_q[k];
      c_d[k]     = c_q[k];
    end
    if (advance) begin
      grp          = cla4(bus.A[3:0], bx_in[3:0], bus.Sub | bus.Cin);
      valid_d[0]   = bus.in_valid;
      a_d[0]       = bus.A;
      bx_d[0]      = bx_in;
      s_d[0]       = '0;
      s_d[0][3:0]  = grp[3:0];
      c_d[0]       = grp[4];
      for (int unsigned k = 1; k < NG; k++) begin
        grp               = cla4(a_q[k-1][4*k +: 4], bx_q[k-1][4*k +: 4], c_q[k-1]);
        valid_d[k]        = valid_q[k-1];
        a_d[k]            = a_q[k-1];
        bx_d[k]           = bx_q[k-1];
        s_d[k]            = s_q[k-1];
        s_d[k][4*k +: 4]  = grp[3:0];
        c_d[k]            = grp[4];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NG; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        bx_q[k]    <= '0;
        s_q[k]     <= '0;
        c_q[k]     <= 1'b0;
      end
    end else begin
      for (int unsigned k = 0; k < NG; k++) begin
        valid_q[k] <= valid_d[k];
        a_q[k]     <= a_d[k];
        bx_q[k]    <= bx_d[k];
        s_q[k]     <= s_d[k];
        c_q[k]     <= c_d[k];
      end
    end
  end

`ifdef CLA_OVF_EN
  // Overflow = carry into MSB xor carry out of MSB, both from the top group.
  function automatic logic ovf4(input logic [3:0] a, input logic [3:0] b, input logic ci);
    logic [4:0] r;
    r = cla4(a, b, ci);
    return (r[3] ^ a[3] ^ b[3]) ^ r[4];
  endfunction

  logic [3:0] top_a;
  logic [3:0] top_b;
  logic       top_c;
  logic       v_q;
  logic       v_d;

  if (NG == 1) begin : g_top_single
    always_comb begin
      top_a = bus.A[WIDTH-1 -: 4];
      top_b = bx_in[WIDTH-1 -: 4];
      top_c = bus.Sub | bus.Cin;
    end
  end else begin : g_top_multi
    always_comb begin
      top_a = a_q[NG-2][WIDTH-1 -: 4];
      top_b = bx_q[NG-2][WIDTH-1 -: 4];
      top_c = c_q[NG-2];
    end
  end

  always_comb begin
    v_d = v_q;
    if (advance) begin
      v_d = ovf4(top_a, top_b, top_c);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

  always_comb bus.V = v_q;
`else
  always_comb bus.V = 1'b0;
`endif

  always_comb begin
    bus.in_ready  = advance;
    bus.out_valid = valid_q[NG-1];
    bus.S         = s_q[NG-1];
    bus.Cout      = c_q[NG-1];
  end
endmodule
